redis_cache_op_sequencer: RTL and testbench

//   Executes one cache command at a time. Sits between the memory-mapped register file
//   (DAT/KEY/CTR) and the cache core. A write to CTR latches operation/key/data from the

---
 rtl/if_types_pkg.sv | 41 ++++
 rtl/redis_cache_op_sequencer.sv | 122 ++++++++++++
 tb/tb_redis_cache_op_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_types_pkg.sv
// Shared types for the cache command path between the register file, the
// op sequencer and the cache core.
package if_types_pkg;

  localparam int RegDataWidth         = 64;
  localparam int RegKeyWidth          = 32;
  localparam int DefaultTimeoutCycles = 255;

  typedef logic [RegDataWidth-1:0] data_bits_t;
  typedef logic [RegKeyWidth-1:0]  key_bits_t;

  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WBACK = 2'd3
  } seq_state_e;

  typedef struct packed {
    data_bits_t dat;
    key_bits_t  key;
    operation_e operation;
  } reg_read_t;

  typedef struct packed {
    data_bits_t dat;
    logic       data_valid;
    logic       busy;
    logic       busy_valid;
    operation_e operation;
    logic       operation_valid;
  } reg_write_t;

endpackage

// File: rtl/redis_cache_op_sequencer.sv
// Runs one cache command at a time: latch from the register file, issue to the
// core, wait for a response or timeout, then write the result back.
module redis_cache_op_sequencer
  import if_types_pkg::*;
#(
  parameter int TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  reg_read_t  reg_read_i,
  output reg_write_t reg_write_o,
  output logic       core_req_valid_o,
  input  logic       core_req_ready_i,
  output operation_e core_req_op_o,
  output key_bits_t  core_req_key_o,
  output data_bits_t core_req_data_o,
  input  logic       core_resp_valid_i,
  input  logic       core_resp_hit_i,
  input  data_bits_t core_resp_data_i,
  output logic       hit_o,
  output logic       timeout_o
);

  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  seq_state_e          state_reg, state_next;
  operation_e          op_reg;
  key_bits_t           key_reg;
  data_bits_t          data_reg;
  data_bits_t          resp_data_reg;
  logic                hit_reg;
  logic                timeout_reg;
  logic                busy_pulse_reg;
  logic [CntWidth-1:0] cnt_reg;
  logic                accept;
  logic                timed_out;

  assign accept    = start_i && (reg_read_i.operation != NOOP);
  assign timed_out = (cnt_reg == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      op_reg         <= NOOP;
      key_reg        <= '0;
      data_reg       <= '0;
      resp_data_reg  <= '0;
      hit_reg        <= 1'b0;
      timeout_reg    <= 1'b0;
      busy_pulse_reg <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      busy_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg         <= reg_read_i.operation;
            key_reg        <= reg_read_i.key;
            data_reg       <= reg_read_i.dat;
            timeout_reg    <= 1'b0;
            busy_pulse_reg <= 1'b1;
          end
        end
        ISSUE: begin
          if (core_req_ready_i) cnt_reg <= '0;
        end
        WAIT: begin
          cnt_reg <= cnt_reg + CntWidth'(1);
          // A response in the last tolerated cycle still counts as a response.
          if (core_resp_valid_i) begin
            hit_reg       <= core_resp_hit_i;
            resp_data_reg <= core_resp_data_i;
          end else if (timed_out) begin
            hit_reg     <= 1'b0;
            timeout_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (core_req_ready_i) state_next = WAIT;
      WAIT:    if (core_resp_valid_i || timed_out) state_next = WBACK;
      WBACK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reg_write_o      = '0;
    core_req_valid_o = (state_reg == ISSUE);
    if (busy_pulse_reg) begin
      reg_write_o.busy       = 1'b1;
      reg_write_o.busy_valid = 1'b1;
    end
    if (state_reg == WBACK) begin
      reg_write_o.busy_valid      = 1'b1;
      reg_write_o.operation       = NOOP;
      reg_write_o.operation_valid = 1'b1;
      // Only READ owns DAT; a miss or timeout returns zero.
      if (op_reg == READ) begin
        reg_write_o.data_valid = 1'b1;
        reg_write_o.dat        = hit_reg ? resp_data_reg : '0;
      end
    end
  end

  assign core_req_op_o   = op_reg;
  assign core_req_key_o  = key_reg;
  assign core_req_data_o = data_reg;
  assign hit_o           = hit_reg;
  assign timeout_o       = timeout_reg;

endmodule

// File: tb/tb_redis_cache_op_sequencer.sv
// Randomized bench for redis_cache_op_sequencer: each command's cycle schedule
// is derived from its ready delay and response delay, then checked every cycle.
module tb_redis_cache_op_sequencer;
  import if_types_pkg::*;

  localparam int TO = 4;

  logic       clk;
  logic       rst_ni;
  logic       start_i;
  reg_read_t  rr;
  reg_write_t reg_write_o;
  logic       core_req_valid_o;
  logic       core_req_ready_i;
  operation_e core_req_op_o;
  key_bits_t  core_req_key_o;
  data_bits_t core_req_data_o;
  logic       core_resp_valid_i;
  logic       core_resp_hit_i;
  data_bits_t core_resp_data_i;
  logic       hit_o;
  logic       timeout_o;

  redis_cache_op_sequencer #(.TimeoutCycles(TO)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .reg_read_i       (rr),
    .reg_write_o      (reg_write_o),
    .core_req_valid_o (core_req_valid_o),
    .core_req_ready_i (core_req_ready_i),
    .core_req_op_o    (core_req_op_o),
    .core_req_key_o   (core_req_key_o),
    .core_req_data_o  (core_req_data_o),
    .core_resp_valid_i(core_resp_valid_i),
    .core_resp_hit_i  (core_resp_hit_i),
    .core_resp_data_i (core_resp_data_i),
    .hit_o            (hit_o),
    .timeout_o        (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: what the outputs must be in the current cycle.
  operation_e m_op;
  key_bits_t  m_key;
  data_bits_t m_data;
  logic       m_hit;
  logic       m_timeout;
  logic       exp_valid;
  reg_write_t exp_rw;

  int total = 0;
  int bad   = 0;

  // Observations of DUT events, used by the hand-computed checks.
  logic       prev_v = 1'b0;
  int         vfirst, vlast, hs_cyc, busy_cyc, wb_cyc, start_cyc;
  int         wb_count = 0, busy_count = 0, v_count = 0;
  data_bits_t wb_dat;
  logic       wb_dv, wb_hit, wb_to;
  int         txn = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    chk("req_valid", 128'(core_req_valid_o), 128'(exp_valid));
    chk("req_op", 128'(core_req_op_o), 128'(m_op));
    chk("req_key", 128'(core_req_key_o), 128'(m_key));
    chk("req_data", 128'(core_req_data_o), 128'(m_data));
    chk("reg_write", 128'(reg_write_o), 128'(exp_rw));
    chk("hit", 128'(hit_o), 128'(m_hit));
    chk("timeout", 128'(timeout_o), 128'(m_timeout));
    if (core_req_valid_o) begin
      if (!prev_v) vfirst = cyc;
      vlast = cyc;
      v_count++;
      if (core_req_ready_i) hs_cyc = cyc;
    end
    prev_v = core_req_valid_o;
    if (reg_write_o.busy_valid && reg_write_o.busy) begin
      busy_cyc = cyc;
      busy_count++;
    end
    if (reg_write_o.operation_valid) begin
      wb_cyc = cyc;
      wb_count++;
      wb_dat = reg_write_o.dat;
      wb_dv  = reg_write_o.data_valid;
      wb_hit = hit_o;
      wb_to  = timeout_o;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    rr.dat            = {$urandom, $urandom};
    rr.key            = $urandom;
    rr.operation      = operation_e'($urandom_range(0, 3));
    start_i           = 1'b0;
    core_req_ready_i  = 1'($urandom_range(0, 1));
    core_resp_valid_i = 1'($urandom_range(0, 1));
    core_resp_hit_i   = 1'($urandom_range(0, 1));
    core_resp_data_i  = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    m_op = NOOP; m_key = '0; m_data = '0; m_hit = 1'b0; m_timeout = 1'b0;
    exp_valid = 1'b0; exp_rw = '0;
  endtask

  // stray: 0 = occasional start pulses while busy, 1 = every busy cycle, 2 = none.
  // abort_k: cycle offset at which reset is pulsed (-1 for none).
  task automatic run_cmd(input operation_e op, input key_bits_t key, input data_bits_t data,
                         input int d, input int r, input logic rhit, input data_bits_t rdata,
                         input int stray, input int abort_k);
    int nwait, kw;
    nwait = (r < TO) ? r + 1 : TO;
    kw    = 2 + d + nwait;
    start_cyc = cyc;
    txn++;
    $display("txn %0d op=%0d key=%h d=%0d r=%0d abort=%0d", txn, op, key, d, r, abort_k);
    for (int k = 0; k <= kw; k++) begin
      randomize_inputs();
      exp_valid = 1'b0;
      exp_rw    = '0;
      if (k == 0) begin
        start_i      = 1'b1;
        rr.dat       = data;
        rr.key       = key;
        rr.operation = op;
      end else begin
        if (stray == 1 || (stray == 0 && $urandom_range(0, 3) == 0)) start_i = 1'b1;
        if (k <= 1 + d) begin
          exp_valid         = 1'b1;
          core_req_ready_i  = (k == 1 + d);
          if (k == 1) begin
            m_op = op; m_key = key; m_data = data; m_timeout = 1'b0;
            exp_rw.busy       = 1'b1;
            exp_rw.busy_valid = 1'b1;
          end
        end else if (k < kw) begin
          core_resp_valid_i = (r < TO) && (k == 2 + d + r);
          if (core_resp_valid_i) begin
            core_resp_hit_i  = rhit;
            core_resp_data_i = rdata;
          end
        end else begin
          m_hit     = (r < TO) ? rhit : 1'b0;
          m_timeout = (r >= TO);
          exp_rw.busy_valid      = 1'b1;
          exp_rw.operation       = NOOP;
          exp_rw.operation_valid = 1'b1;
          if (op == READ) begin
            exp_rw.data_valid = 1'b1;
            exp_rw.dat        = (r < TO && rhit) ? rdata : '0;
          end
        end
      end
      if (k == abort_k) begin
        start_i = 1'b0;
        #1;
        rst_ni = 1'b0;
        model_reset();
        #1;
        compare_all();
        step();
        rst_ni = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic idle_cycles(input int n, input logic force_noop);
    for (int i = 0; i < n; i++) begin
      randomize_inputs();
      start_i = force_noop ? 1'b1 : 1'($urandom_range(0, 1));
      if (start_i) rr.operation = NOOP;
      exp_valid = 1'b0;
      exp_rw    = '0;
      step();
    end
  endtask

  initial begin
    int wb_before, busy_before, v_before;
    rst_ni = 1'b0;
    randomize_inputs();
    model_reset();
    step();
    step();
    rst_ni = 1'b1;

    // NOOP starts in IDLE do nothing.
    busy_before = busy_count; v_before = v_count;
    idle_cycles(5, 1'b1);
    chk("t6_no_busy", 128'(busy_count), 128'(busy_before));
    chk("t6_no_req", 128'(v_count), 128'(v_before));

    // READ hit with a zero-wait core.
    run_cmd(READ, 32'hDEADBEEF, 64'h1111_2222_3333_4444, 0, 0, 1'b1,
            64'h0123_4567_89AB_CDEF, 2, -1);
    chk("t1_wb_dat", 128'(wb_dat), 128'(64'h0123_4567_89AB_CDEF));
    chk("t1_hit", 128'(wb_hit), 128'(1'b1));
    chk("t1_busy_lat", 128'(busy_cyc - start_cyc), 128'(1));
    chk("t1_wb_lat", 128'(wb_cyc - start_cyc), 128'(3));
    idle_cycles(1, 1'b0);

    // UPSERT with ready held off five cycles.
    run_cmd(UPSERT, 32'h0BAD_F00D, 64'hCAFE_BABE_0000_0001, 5, 1, 1'b1, 64'h5, 2, -1);
    chk("t2_valid_len", 128'(vlast - vfirst + 1), 128'(6));
    chk("t2_data_valid", 128'(wb_dv), 128'(1'b0));
    chk("t2_hit", 128'(wb_hit), 128'(1'b1));

    // Timeout on a READ: four WAIT cycles between handshake and write-back.
    run_cmd(READ, 32'h1234_5678, 64'h9, 1, 9, 1'b1, 64'hFFFF, 2, -1);
    chk("t3_wait_cycles", 128'(wb_cyc - hs_cyc - 1), 128'(4));
    chk("t3_timeout", 128'(wb_to), 128'(1'b1));
    chk("t3_hit", 128'(wb_hit), 128'(1'b0));
    chk("t3_dat", 128'(wb_dat), 128'(0));
    chk("t3_data_valid", 128'(wb_dv), 128'(1'b1));

    // Start pulses every busy cycle are ignored; exactly one write-back.
    wb_before = wb_count;
    run_cmd(DELETE, 32'hA5A5_5A5A, 64'h7, 1, 3, 1'b0, 64'h0, 1, -1);
    chk("t4_one_wback", 128'(wb_count - wb_before), 128'(1));

    // Reset during WAIT aborts without write-back; the next READ completes.
    wb_before = wb_count;
    run_cmd(READ, 32'h7777_0000, 64'h3, 0, 3, 1'b1, 64'h42, 2, 3);
    chk("t5_no_wback", 128'(wb_count), 128'(wb_before));
    run_cmd(READ, 32'h7777_0001, 64'h4, 0, 1, 1'b1, 64'h0000_0000_DEAD_0042, 2, -1);
    chk("t5_recover_dat", 128'(wb_dat), 128'(64'h0000_0000_DEAD_0042));

    for (int n = 0; n < 150; n++) begin
      operation_e op;
      int d, r, nw, ab;
      op = operation_e'($urandom_range(1, 3));
      d  = $urandom_range(0, 3);
      r  = $urandom_range(0, 5);
      nw = (r < TO) ? r + 1 : TO;
      ab = ($urandom_range(0, 14) == 0) ? 2 + d + $urandom_range(0, nw - 1) : -1;
      run_cmd(op, $urandom, {$urandom, $urandom}, d, r, 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, 0, ab);
      idle_cycles($urandom_range(0, 2), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
